// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory request/response bundle.
// The fetch stage is the master: it raises req/addr and receives gnt,
// then rvalid/rdata once per granted request, in order.
`timescale 1ns/1ps
interface fetch_unit_if;
    logic        req;
    logic [31:0] addr;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (
        output req,
        output addr,
        input  gnt,
        input  rvalid,
        input  rdata
    );

    modport slave (
        input  req,
        input  addr,
        output gnt,
        output rvalid,
        output rdata
    );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage feeding the IF/ID register.
// Keeps the fetch PC and allows at most one request in flight to instruction
// memory. Returned words are queued in a small buffer, and the buffer head
// drives the outputs. A redirect flushes the buffer, and a response still in
// flight is discarded through the DROP state.
`timescale 1ns/1ps
module fetch_unit #(
    parameter logic [31:0] PC_RESET = 32'h0000_3000,
    parameter int          DEPTH    = 2
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               stall,
    input  logic               redirect,
    input  logic [31:0]        pc_target,
    fetch_unit_if.master       imem,
    output logic               valid_out,
    output logic [31:0]        pc_cur_out,
    output logic [31:0]        inst_out,
    output logic [31:0]        pc_add4_out
);

    localparam int          PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int          CW  = $clog2(DEPTH) + 1;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [31:0]       fetch_pc;
    logic [31:0]       pc_buf   [DEPTH];
    logic [31:0]       inst_buf [DEPTH];
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;
    logic [CW-1:0]     count;

    logic              push;
    logic              pop;
    logic              space;
    logic              grant;
    logic [CW:0]       eff_count;

    // An entry leaves when the head is valid and downstream is not stalled.
    // An entry arrives when the outstanding request returns and it is not
    // being flushed. A new request may issue only if the buffer keeps room for
    // that request's eventual response after this cycle's push and pop.
    assign pop       = valid_out && !stall;
    assign push      = (state == ST_WAIT) && imem.rvalid && !redirect;
    assign eff_count = {1'b0, count} + {{CW{1'b0}}, push} - {{CW{1'b0}}, pop};
    assign space     = eff_count < (CW+1)'(DEPTH);
    assign grant     = imem.req && imem.gnt;

    // The state register holds the request tracker: idle, waiting, or discarding.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= ST_RUN;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and request issue. A request may reissue in the same cycle its predecessor returns.
    always_comb begin
        state_next = state;
        imem.req   = 1'b0;
        imem.addr  = push ? (fetch_pc + 32'd4) : fetch_pc;

        imem.req = rstn && !redirect && space &&
                   ((state == ST_RUN) || ((state == ST_WAIT) && imem.rvalid));

        case (state)
            ST_RUN: begin
                if (!redirect && grant) begin
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (imem.rvalid) begin
                    if (!redirect && grant) begin
                        state_next = ST_WAIT;
                    end else begin
                        state_next = ST_RUN;
                    end
                end else if (redirect) begin
                    state_next = ST_DROP;
                end
            end
            ST_DROP: begin
                // Only the stale response is ever outstanding here, so once
                // it returns (even alongside a new redirect) we are idle.
                if (imem.rvalid) begin
                    state_next = ST_RUN;
                end
            end
            default: begin
                state_next = ST_RUN;
            end
        endcase
    end

    // Fetch PC and buffer bookkeeping. A redirect overrides everything else.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fetch_pc <= PC_RESET;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else if (redirect) begin
            fetch_pc <= pc_target;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            if (push) begin
                fetch_pc <= fetch_pc + 32'd4;
                wr_ptr   <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= eff_count[CW-1:0];
        end
    end

    // Buffer storage. The count and pointers decide which entries are live, so the storage needs no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_buf[wr_ptr]   <= fetch_pc;
            inst_buf[wr_ptr] <= imem.rdata;
        end
    end

    // Outputs come only from buffer state. An empty buffer presents a NOP with zero PCs.
    always_comb begin
        valid_out   = (count != '0);
        pc_cur_out  = 32'd0;
        inst_out    = NOP;
        pc_add4_out = 32'd0;
        if (valid_out) begin
            pc_cur_out  = pc_buf[rd_ptr];
            inst_out    = inst_buf[rd_ptr];
            pc_add4_out = pc_buf[rd_ptr] + 32'd4;
        end
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage that sits directly upstream of the IF/ID segment register.
- Owns the fetch PC and issues requests to instruction memory over a variable-latency req/gnt + rvalid handshake.
- Buffers returned instructions in a small FIFO and presents {pc_cur, inst, pc_add4} plus valid_out to the IF/ID register.
- Honours pipeline stall, and discards wrong-path fetches on redirect (taken branch, jal, jalr).

Parameters:
PC_RESET, 32'h0000_3000, fetch PC after reset
DEPTH, 2, instruction buffer entries (power of 2, >=2)

Ports:
clk  in  1  clock, all state on rising edge
rstn  in  1  asynchronous active-low reset
stall  in  1  downstream stall; head entry is held
redirect  in  1  taken branch/jump from EX; flush fetch state
pc_target  in  32  new fetch PC when redirect=1
imem_req  out  1  request valid
imem_addr  out  32  request address (fetch_pc)
imem_gnt  in  1  request accepted this cycle when imem_req=1
imem_rvalid  in  1  response valid (one per granted request, in order)
imem_rdata  in  32  instruction word
valid_out  out  1  head entry valid
pc_cur_out  out  32  head PC
inst_out  out  32  head instruction
pc_add4_out  out  32  head PC + 4

Behaviour:
- Reset (async, rstn=0):
  - fetch_pc=PC_RESET; state=RUN; buffer empty; count=0.
  - imem_req=0, valid_out=0, inst_out=32'h0000_0013, pc_cur_out=0, pc_add4_out=0.
- FSM states:
  - RUN: no request outstanding.
  - WAIT: one granted request outstanding.
  - DROP: outstanding request whose response must be discarded.
- At most one request outstanding.
- space = (count < DEPTH), accounting for a pop in the same cycle.
- imem_req = !redirect && space && (state==RUN || (state==WAIT && imem_rvalid)).
- imem_addr=fetch_pc. On response-and-reissue in the same cycle, imem_addr = fetch_pc+4.
- Grant (imem_req && imem_gnt): state->WAIT.
- WAIT with imem_rvalid and no redirect:
  - push {fetch_pc, imem_rdata}; fetch_pc += 4.
  - state->WAIT if re-issued and granted that cycle, else RUN.
- Back-to-back case: with gnt=1 and rvalid=1 every cycle, sustain 1 instruction/cycle.
- Output:
  - Head of buffer drives the outputs; they are registered-state driven, with no combinational path from imem_rdata.
  - pc_add4_out = head pc + 4, modulo 2^32.
  - Empty buffer: valid_out=0, inst_out=NOP 0x00000013, pc outputs 0.
- Pop when valid_out && !stall. Push and pop in the same cycle leave count unchanged.
- Full (count==DEPTH) with no pop: imem_req=0. A pending response is still accepted, because issue was gated on space.
- Redirect (highest priority, same edge):
  - Buffer cleared, count=0, fetch_pc=pc_target, imem_req=0 that cycle.
  - WAIT without rvalid -> DROP.
  - WAIT with rvalid -> response discarded, RUN.
  - RUN -> RUN.
  - DROP -> DROP, with the new target.
- DROP: imem_req=0. The next rvalid is discarded, then state -> RUN.
- stall and redirect together: redirect wins and the buffer is flushed.
- rvalid in RUN is ignored, which covers stray responses after a mid-operation reset.
- Instruction memory must be reset together with this block.
- pc_target is used verbatim; there is no alignment check.

Test Plan:
- Reset release, gnt=1, rvalid one cycle after each grant, stall=0 -> fetches 0x3000, 0x3004, 0x3008 at 1/cycle; valid_out from cycle 2; pc_add4_out=0x3004 with pc 0x3000.
- stall=1 for 4 cycles with memory always ready -> buffer fills to 2, imem_req drops, head stays pc=0x3000; after release, order is 0x3000, 0x3004, 0x3008 with no loss or duplication.
- Redirect to 0x3100 while WAIT, rvalid arrives 3 cycles later -> DROP; that response (for 0x3008) is discarded; next request addr=0x3100; valid_out=0 until 0x3100 returns.
- Redirect in the same cycle as rvalid -> response dropped, no push, next imem_addr=0x3100 the following cycle.
- gnt held low for 5 cycles -> imem_req stays 1 with constant addr, valid_out=0, inst_out=0x00000013.
- rstn asserted mid-WAIT, then rvalid arrives after release -> ignored; first fetch addr=0x3000.
